fork_join_dispatcher: RTL and testbench
=======================================

Name: fork_join_dispatcher

Overview:
- Parametrised successor to the two-channel controller. Fans out one command to N_CHAN worker channels in fork/join fashion: sends complete in any order, and all must complete before the join.
- Then collects one response on a shared response channel and returns it to the issuer.
- Adds a per-transaction progress watchdog that reports a stalled fork or stalled receive as a sticky deadlock flag. Sits between a command source and a bank of channel-connected workers.

Parameters:
- N_CHAN, 2, number of outbound worker channels (1..16).
- DATA_W, 8, payload width of every channel.
- TIMEOUT, 64, cycles without handshake progress before deadlock is declared; 0 disables the watchdog.
- IDX_OFFSET, 1, 1 = channel i receives cmd+i (mod 2^DATA_W); 0 = every channel receives cmd.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  high only in IDLE.
- cmd_data  in  DATA_W  command value.
- req_valid  out  N_CHAN  per-channel send valid.
- req_ready  in  N_CHAN  per-channel send ready.
- req_data  out  N_CHAN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- rsp_valid  in  1  response offer from workers.
- rsp_ready  out  1  high only in RECV.
- rsp_data  in  DATA_W  response value.
- done_valid  out  1  one-cycle pulse with the result.
- done_data  out  DATA_W  captured response, held until next capture.
- deadlock  out  1  sticky stall indication.
- deadlock_state  out  2  state encoding at the moment of stall.
- clear  in  1  clears deadlock and returns to IDLE.

Behaviour:
- Handshake rules:
  - A transfer occurs on any cycle with valid && ready.
  - valid, once raised, holds until the transfer occurs.
  - data is stable while valid is high.
- Reset (rst=1 at posedge), evaluated before every other condition:
  - state=IDLE, sent mask=0, watchdog count=0.
  - All outputs 0: req_valid, req_data, rsp_ready, done_valid, done_data, deadlock, deadlock_state. cmd_ready=1 the cycle after reset.
  - Reset mid-transaction abandons it with no done pulse.
- States: IDLE(0), SEND(1), RECV(2), STALL(3).
- IDLE:
  - cmd_ready=1.
  - On cmd transfer: latch cmd_data, sent=0, count=0, go to SEND.
- SEND:
  - req_valid[i] = ~sent[i].
  - req_data[i] = cmd + (IDX_OFFSET ? i : 0), truncated to DATA_W.
  - Each channel transfer sets sent[i]. Multiple channels may transfer in the same cycle.
  - When (sent | transfers-this-cycle) is all ones, go to RECV next cycle. Join latency is 0 extra cycles after the last send.
- RECV:
  - rsp_ready=1, all req_valid=0.
  - On rsp transfer: done_data<=rsp_data, done_valid=1 the next cycle, go to IDLE.
  - A command may be accepted in the cycle done_valid is high, so back-to-back throughput is N_CHAN-free minimum 3 cycles/command.
  - rsp_valid outside RECV is ignored (rsp_ready=0).
- Watchdog, active in SEND and RECV only:
  - count resets to 0 on any handshake and on state entry; otherwise increments.
  - When count reaches TIMEOUT-1 with no handshake that cycle: go to STALL, deadlock<=1, deadlock_state<=the stalled state.
  - A handshake in that same cycle wins: no stall.
  - TIMEOUT=0: never stalls.
  - Counter width is $clog2(TIMEOUT+1), saturating.
- STALL:
  - All valids/readys low, cmd_ready=0.
  - deadlock held until clear=1 (synchronous); then go to IDLE, deadlock=0, deadlock_state=0.
  - clear in any other state has no effect.
- Simultaneous rst and clear: rst wins.

Decomposition:
- Shared package (chan_pkg):
  - state_e enum {IDLE, SEND, RECV, STALL} as logic [1:0].
  - A default DATA_W localparam.
  - Function chan_payload(cmd, idx, offset_en).
- One natural sub-module: progress_watchdog (params TIMEOUT).
  - Inputs: clk, rst, active, progress.
  - Output: expired.
  - Reused by later channel blocks.

Test Plan:
- N_CHAN=2, IDX_OFFSET=1, cmd=0x10, both req_ready=1, rsp 0x2A after 1 cycle:
  - req_data = {0x11, 0x10}, both sent in 1 cycle.
  - done_data=0x2A, single done_valid pulse.
- N_CHAN=4, ready order 3,0,2,1 on separate cycles:
  - Each req_valid drops exactly after its own transfer.
  - rsp_ready rises the cycle after channel 1 transfers.
- TIMEOUT=8, req_ready[1] held 0:
  - deadlock=1 and deadlock_state=1 exactly 8 cycles after SEND entry.
  - clear returns to IDLE; a new cmd is then accepted.
- TIMEOUT=8, rsp_valid never asserted:
  - deadlock_state=2 after 8 cycles.
  - Variant: rsp_valid arrives on cycle 8 (count=7) → done, no deadlock.
- rst asserted in SEND with sent=0b01:
  - All outputs 0 the next cycle, no done_valid.
  - Stale rsp_valid pulse is ignored.
- TIMEOUT=0, stall 1000 cycles:
  - deadlock stays 0.
  - Releasing ready completes normally, result 0x00 for IDX_OFFSET=0, cmd=0x00, rsp=0x00.

Source files
------------

// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared state encoding and payload helper for channel dispatch blocks
package chan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      RECV  = 2'd2,
      STALL = 2'd3
   } state_e;

   localparam int DEFAULT_DATA_W = 8;
   localparam int MAX_DATA_W     = 32;

   // Callers truncate the result to their own width, which gives the sum modulo 2^DATA_W.
   function automatic logic [MAX_DATA_W-1:0] chan_payload(
      input logic [MAX_DATA_W-1:0] cmd,
      input int unsigned           idx,
      input logic                  offset_en
   );
      return offset_en ? cmd + MAX_DATA_W'(idx) : cmd;
   endfunction

endpackage

// File: rtl/fork_join_dispatcher_if.sv
// rtl/fork_join_dispatcher_if.sv - command, fan-out request, shared response and result bundle
interface fork_join_dispatcher_if #(
   parameter int N_CHAN = 2,
   parameter int DATA_W = chan_pkg::DEFAULT_DATA_W
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [DATA_W-1:0]        cmd_data;
   logic [N_CHAN-1:0]        req_valid;
   logic [N_CHAN-1:0]        req_ready;
   logic [N_CHAN*DATA_W-1:0] req_data;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_W-1:0]        rsp_data;
   logic                     done_valid;
   logic [DATA_W-1:0]        done_data;

   modport master (
      input  cmd_valid, cmd_data, req_ready, rsp_valid, rsp_data,
      output cmd_ready, req_valid, req_data, rsp_ready, done_valid, done_data
   );

   modport slave (
      output cmd_valid, cmd_data, req_ready, rsp_valid, rsp_data,
      input  cmd_ready, req_valid, req_data, rsp_ready, done_valid, done_data
   );
endinterface

// File: rtl/progress_watchdog.sv
// rtl/progress_watchdog.sv - counts cycles without progress while active; TIMEOUT=0 never expires
module progress_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic progress,
   output logic expired
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] count;

   // Leaving the active states clears the count, so every state entry starts from zero.
   always_ff @(posedge clk) begin
      if (rst || !active || progress) begin
         count <= '0;
      end else if (count != {CW{1'b1}}) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (TIMEOUT > 0) && active && !progress && (count == LIMIT);

endmodule

// File: rtl/fork_join_dispatcher.sv
// rtl/fork_join_dispatcher.sv - forks one command to N_CHAN channels, joins, then returns one response
module fork_join_dispatcher
   import chan_pkg::*;
#(
   parameter int N_CHAN     = 2,
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int TIMEOUT    = 64,
   parameter int IDX_OFFSET = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   fork_join_dispatcher_if.master bus,
   input  logic                   clear,
   output logic                   deadlock,
   output logic [1:0]             deadlock_state
);
   state_e            state;
   state_e            state_d;
   logic [N_CHAN-1:0] sent;
   logic [N_CHAN-1:0] xfer;
   logic [DATA_W-1:0] cmd_q;
   logic              cmd_fire;
   logic              rsp_fire;
   logic              active;
   logic              progress;
   logic              expired;

   assign bus.cmd_ready = (state == IDLE);
   assign bus.req_valid = (state == SEND) ? ~sent : '0;
   assign bus.rsp_ready = (state == RECV);

   assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
   assign rsp_fire = bus.rsp_valid && bus.rsp_ready;
   assign xfer     = bus.req_valid & bus.req_ready;
   assign active   = (state == SEND) || (state == RECV);
   assign progress = (|xfer) || rsp_fire;

   always_comb begin
      bus.req_data = '0;
      if (state == SEND) begin
         for (int i = 0; i < N_CHAN; i++) begin
            bus.req_data[i*DATA_W +: DATA_W] =
               DATA_W'(chan_payload(MAX_DATA_W'(cmd_q), i, IDX_OFFSET != 0));
         end
      end
   end

   progress_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .active   (active),
      .progress (progress),
      .expired  (expired)
   );

   // Join counts this cycle's transfers, so RECV follows the last send with no extra cycle.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (cmd_fire) state_d = SEND;
         SEND:    if (expired) state_d = STALL;
                  else if (&(sent | xfer)) state_d = RECV;
         RECV:    if (expired) state_d = STALL;
                  else if (rsp_fire) state_d = IDLE;
         STALL:   if (clear) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         sent           <= '0;
         cmd_q          <= '0;
         bus.done_valid <= 1'b0;
         bus.done_data  <= '0;
         deadlock       <= 1'b0;
         deadlock_state <= 2'd0;
      end else begin
         state          <= state_d;
         bus.done_valid <= rsp_fire;
         if (rsp_fire) begin
            bus.done_data <= bus.rsp_data;
         end
         if (cmd_fire) begin
            cmd_q <= bus.cmd_data;
            sent  <= '0;
         end else if (state == SEND) begin
            sent <= sent | xfer;
         end
         if (expired) begin
            deadlock       <= 1'b1;
            deadlock_state <= state;
         end else if ((state == STALL) && clear) begin
            deadlock       <= 1'b0;
            deadlock_state <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_fork_join_dispatcher.sv
// tb/tb_fork_join_dispatcher.sv - scoreboard bench: event queue model vs. two dispatcher configurations
module tb_fork_join_dispatcher;

   localparam int NA = 4;
   localparam int TA = 8;
   localparam int K_CMD  = 0;
   localparam int K_REQ  = 1;
   localparam int K_DONE = 2;
   localparam int K_DL   = 3;

   typedef struct {
      int         kind;
      int         chan;
      logic [7:0] val;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       deadlock_a, deadlock_b;
   logic [1:0] dstate_a, dstate_b;
   logic       dl_prev = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         dly [NA];
   ev_t        expq [$];

   fork_join_dispatcher_if #(.N_CHAN(NA), .DATA_W(8)) bus_a ();
   fork_join_dispatcher_if #(.N_CHAN(2),  .DATA_W(8)) bus_b ();

   fork_join_dispatcher #(.N_CHAN(NA), .DATA_W(8), .TIMEOUT(TA), .IDX_OFFSET(1)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .clear(clear),
      .deadlock(deadlock_a), .deadlock_state(dstate_a)
   );

   fork_join_dispatcher #(.N_CHAN(2), .DATA_W(8), .TIMEOUT(0), .IDX_OFFSET(0)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .clear(clear),
      .deadlock(deadlock_b), .deadlock_state(dstate_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int chan, input logic [7:0] val, input int c);
      ev_t e;
      e.kind = kind; e.chan = chan; e.val = val; e.cyc = c;
      expq.push_back(e);
   endtask

   task automatic observe(input int kind, input int chan, input logic [7:0] val);
      ev_t e;
      checks++;
      if (expq.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event got kind=%0d chan=%0d val=%h cyc=%0d required none",
                  kind, chan, val, cyc);
      end else begin
         e = expq.pop_front();
         if (e.kind != kind || e.chan != chan || e.val !== val || e.cyc != cyc) begin
            errors++;
            $display("FAIL event got kind=%0d chan=%0d val=%h cyc=%0d required kind=%0d chan=%0d val=%h cyc=%0d",
                     kind, chan, val, cyc, e.kind, e.chan, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: every observable event of dut_a is matched against the expected queue.
   always @(negedge clk) begin
      if (bus_a.done_valid) observe(K_DONE, 0, bus_a.done_data);
      if (deadlock_a && !dl_prev) observe(K_DL, 0, {6'b0, dstate_a});
      if (!deadlock_a && dl_prev) chk("deadlock_state_cleared", 32'(dstate_a), 32'd0);
      if (bus_a.cmd_valid && bus_a.cmd_ready) observe(K_CMD, 0, bus_a.cmd_data);
      for (int i = 0; i < NA; i++) begin
         if (bus_a.req_valid[i] && bus_a.req_ready[i]) observe(K_REQ, i, bus_a.req_data[i*8 +: 8]);
      end
      dl_prev <= deadlock_a;
   end

   task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
   endtask

   // Model: channel i becomes ready d_i cycles into the fork, the response r cycles into the join.
   // A run of more than TA cycles with no handshake ends in a stall at its TA-th cycle.
   task automatic run_txn(input logic [7:0] cmd, input logic [7:0] rsp, input int r);
      int  t [$];
      int  last, kst, m, c0, e, k;
      bit  stall;
      c0 = cyc;
      bus_a.cmd_valid = 1'b1;
      bus_a.cmd_data  = cmd;
      push(K_CMD, 0, cmd, c0);
      foreach (dly[i]) t.push_back(dly[i]);
      t.sort();
      last = -1;
      kst  = -1;
      foreach (t[j]) begin
         if (kst < 0) begin
            if (t[j] - last > TA) kst = last + TA;
            else last = t[j];
         end
      end
      m = t[NA-1];
      for (int kk = 0; kk <= m; kk++) begin
         for (int i = 0; i < NA; i++) begin
            if (dly[i] == kk && (kst < 0 || kk < kst)) push(K_REQ, i, 8'(cmd + 8'(i)), c0 + 1 + kk);
         end
      end
      stall = 1'b1;
      if (kst >= 0) begin
         e = c0 + 2 + kst;
         push(K_DL, 0, 8'd1, e);
      end else if (r >= TA) begin
         e = c0 + 2 + m + TA;
         push(K_DL, 0, 8'd2, e);
      end else begin
         e = c0 + 3 + m + r;
         push(K_DONE, 0, rsp, e);
         stall = 1'b0;
      end
      @(posedge clk); #1;
      bus_a.cmd_valid = 1'b0;
      while (cyc < e) begin
         k = cyc - c0 - 1;
         for (int i = 0; i < NA; i++) bus_a.req_ready[i] = (k >= dly[i]);
         bus_a.rsp_valid = (kst < 0) && (k == m + 1 + r);
         bus_a.rsp_data  = rsp;
         @(posedge clk); #1;
      end
      bus_a.req_ready = '0;
      bus_a.rsp_valid = 1'b0;
      if (stall) begin
         clear = 1'b1;
         @(posedge clk); #1;
         clear = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] cb, rb;
      logic       b_dl;
      int         c0, r;
      rst = 1'b1;
      clear = 1'b0;
      bus_a.cmd_valid = 1'b0; bus_a.cmd_data = '0; bus_a.req_ready = '0;
      bus_a.rsp_valid = 1'b0; bus_a.rsp_data = '0;
      bus_b.cmd_valid = 1'b0; bus_b.cmd_data = '0; bus_b.req_ready = '0;
      bus_b.rsp_valid = 1'b0; bus_b.rsp_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
      chk("rst_req_valid", 32'(bus_a.req_valid), 32'd0);
      chk("rst_req_data", bus_a.req_data, 32'd0);
      chk("rst_rsp_ready", 32'(bus_a.rsp_ready), 32'd0);
      chk("rst_done", {23'd0, bus_a.done_valid, bus_a.done_data}, 32'd0);
      chk("rst_deadlock", {29'd0, deadlock_a, dstate_a}, 32'd0);
      chk("rst_b_cmd_ready", 32'(bus_b.cmd_ready), 32'd1);
      @(posedge clk); #1;

      // Reset in the middle of a fork with only channel 0 sent.
      c0 = cyc;
      bus_a.cmd_valid = 1'b1; bus_a.cmd_data = 8'h55;
      push(K_CMD, 0, 8'h55, c0);
      push(K_REQ, 0, 8'h55, c0 + 1);
      @(posedge clk); #1;
      bus_a.cmd_valid = 1'b0;
      bus_a.req_ready = 4'b0001;
      @(posedge clk); #1;
      bus_a.req_ready = '0;
      @(negedge clk);
      chk("partial_req_valid", 32'(bus_a.req_valid), 32'hE);
      rst = 1'b1;
      bus_a.rsp_valid = 1'b1; bus_a.rsp_data = 8'hEE;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_req_valid", 32'(bus_a.req_valid), 32'd0);
      chk("midrst_req_data", bus_a.req_data, 32'd0);
      chk("midrst_rsp_ready", 32'(bus_a.rsp_ready), 32'd0);
      chk("midrst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
      @(posedge clk); #1;
      bus_a.rsp_valid = 1'b0;
      @(negedge clk);
      chk("stale_rsp_no_done", 32'(bus_a.done_valid), 32'd0);
      @(posedge clk); #1;

      set_dly(0, 0, 0, 0);   run_txn(8'h10, 8'h2A, 1);
      set_dly(1, 3, 2, 0);   run_txn(8'hFE, 8'h33, 0);
      set_dly(0, 30, 0, 0);  run_txn(8'h20, 8'h00, 0);
      set_dly(0, 0, 0, 0);   run_txn(8'h30, 8'h44, 20);
      set_dly(2, 0, 1, 0);   run_txn(8'h40, 8'h5A, 7);
      set_dly(0, 1, 0, 2);   run_txn(8'h50, 8'h66, 8);
      set_dly(8, 8, 8, 8);   run_txn(8'h60, 8'h77, 0);
      set_dly(7, 7, 7, 7);   run_txn(8'h70, 8'h88, 0);
      set_dly(0, 7, 14, 21); run_txn(8'h80, 8'h99, 2);

      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < NA; i++) begin
            dly[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 4));
         end
         r = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
         run_txn(8'($urandom), 8'($urandom), r);
      end

      // Watchdog disabled: a long stall must never report deadlock.
      cb = 8'($urandom);
      rb = 8'($urandom);
      b_dl = 1'b0;
      bus_b.cmd_valid = 1'b1; bus_b.cmd_data = cb;
      @(posedge clk); #1;
      bus_b.cmd_valid = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (deadlock_b) b_dl = 1'b1;
      end
      chk("b_no_deadlock", 32'(b_dl), 32'd0);
      chk("b_req_valid_held", 32'(bus_b.req_valid), 32'd3);
      chk("b_req_data", 32'(bus_b.req_data), 32'({cb, cb}));
      bus_b.req_ready = 2'b11;
      @(posedge clk); #1;
      bus_b.req_ready = 2'b00;
      @(negedge clk);
      chk("b_join_rsp_ready", 32'(bus_b.rsp_ready), 32'd1);
      bus_b.rsp_valid = 1'b1; bus_b.rsp_data = rb;
      @(posedge clk); #1;
      bus_b.rsp_valid = 1'b0;
      @(negedge clk);
      chk("b_done_valid", 32'(bus_b.done_valid), 32'd1);
      chk("b_done_data", 32'(bus_b.done_data), 32'(rb));
      @(negedge clk);
      chk("b_done_single_pulse", 32'(bus_b.done_valid), 32'd0);
      chk("b_back_idle", 32'(bus_b.cmd_ready), 32'd1);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
